regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- Writeback/operand stage wrapped around the 8-bit ALU.
- Holds the architectural register file.
- Consumes the ALU result, carry-out, zero/parity/equal and the two write-select strobes.
- Supplies operands A/B, the dedicated R0 value, and the registered carry that feeds the ALU carry-in next instruction.

Parameters:
- DW, 8, datapath width in bits.
- NREGS, 8, number of architectural registers (R0..R7).
- AW, $clog2(NREGS), register address width (derived, not overridable).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- stall_i  input  1  freeze: blocks every register and flag update this cycle
- raddr_a_i  input  AW  read address, operand A
- raddr_b_i  input  AW  read address, operand B
- waddr_first_i  input  AW  destination for first-register writes
- rslt_i  input  DW  ALU result
- write_first_i  input  1  write rslt_i to waddr_first_i
- write_r0_i  input  1  write rslt_i to R0
- flag_we_i  input  1  latch carry/zero/pari/equal
- carry_clr_i  input  1  force carry flag to 0
- sc_i  input  1  ALU carry/shift-out
- zero_i  input  1  ALU zero flag
- pari_i  input  1  ALU parity flag
- equal_i  input  1  ALU equality flag
- data_a_o  output  DW  operand A read data
- data_b_o  output  DW  operand B read data
- r0_o  output  DW  current R0 contents
- carry_o  output  1  registered carry, drives ALU carry-in
- zero_o  output  1  registered zero flag
- pari_o  output  1  registered parity flag
- equal_o  output  1  registered equal flag, consumed by branch logic

Behaviour:
- Reset, when rst_n=0 at a rising edge:
  - all registers go to 0; carry_o, zero_o, pari_o, equal_o go to 0.
  - Reset beats stall_i and every write strobe.
- Reads are combinational; data_a_o and data_b_o reflect register contents (see bypass under Optional Feature).
- r0_o is always the stored R0.
- Write port, with stall_i=0:
  - write_first_i=1: reg[waddr_first_i] <= rslt_i.
  - write_r0_i=1: reg[0] <= rslt_i.
  - Both set: both destinations receive rslt_i. If waddr_first_i=0 this is a single write. No error.
  - Neither set: no register changes.
  - Write latency 1 cycle: the new value is visible on reads the cycle after the strobe.
- Flags, with stall_i=0:
  - flag_we_i=1: carry<=sc_i, zero<=zero_i, pari<=pari_i, equal<=equal_i.
  - carry_clr_i=1: carry<=0, overriding flag_we_i for carry only; zero, pari and equal still update if flag_we_i=1.
  - Flags hold otherwise.
- stall_i=1: registers and flags hold regardless of the write, flag and clear strobes. Reads stay live.
- No wrap-around conditions: all addresses are in range by construction, because NREGS is a power of two.
- Mid-operation reset clears state on that edge. The strobes of that cycle are discarded.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read address equal to an address being written this cycle returns rslt_i combinationally on that read port. This covers the write_first target and R0 under write_r0. r0_o also bypasses under write_r0_i or write_first_i to address 0. Bypass is suppressed when stall_i=1 or rst_n=0.
- Not defined: reads return the stored (old) value during a write cycle.

Decomposition:
- Shared package holds:
  - DW and AW constants.
  - A flags_t packed struct {carry, zero, pari, equal}.
  - The ALU opcode enum, shared with the ALU and the decoder.
- One sub-module, wb_flags: the flag register with the clear-override and stall logic.
- Register array and bypass muxing stay in the top module.

Test Plan:
1. Hold rst_n=0 for 2 cycles after writing 8'hAA to R3 -> every read returns 0; carry_o=0, zero_o=0, pari_o=0, equal_o=0.
2. write_first_i=1, waddr_first_i=5, rslt_i=8'h3C; next cycle raddr_a_i=5 -> data_a_o=8'h3C. R0 stays unchanged.
3. write_first_i=1 and write_r0_i=1, waddr_first_i=2, rslt_i=8'h81 -> R2=8'h81 and R0=8'h81; r0_o=8'h81 the following cycle.
4. flag_we_i=1 with sc_i=1, zero_i=0, pari_i=1, equal_i=1 -> carry_o=1, pari_o=1, equal_o=1. Next cycle flag_we_i=1 with carry_clr_i=1 and sc_i=1 -> carry_o=0, other flags follow their inputs.
5. stall_i=1 with write_first_i=1, waddr_first_i=4, rslt_i=8'hFF, flag_we_i=1 -> R4 and flags are unchanged on the next cycle.
6. With REGFILE_BYPASS_EN: write R6=8'h5A while raddr_b_i=6 -> data_b_o=8'h5A in the same cycle. Without the macro -> data_b_o shows the old R6 value.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the writeback/operand stage, the ALU and the decoder.
package regfile_wb_pkg;

    localparam int DW    = 8;
    localparam int NREGS = 8;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic carry;
        logic zero;
        logic pari;
        logic equal;
    } flags_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SHL = 4'd7,
        ALU_SHR = 4'd8,
        ALU_ROL = 4'd9,
        ALU_ROR = 4'd10,
        ALU_CMP = 4'd11,
        ALU_MOV = 4'd12,
        ALU_NOP = 4'd15
    } alu_op_e;

endpackage

// File: rtl/regfile_wb_flags.sv
// Flag register (carry/zero/parity/equal) with carry-clear override and stall hold.
module wb_flags
    import regfile_wb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall_i,
    input  logic   flag_we_i,
    input  logic   carry_clr_i,
    input  flags_t flags_i,
    output flags_t flags_o
);

    flags_t flags_d;
    flags_t flags_q;

    always_comb begin
        // NOTE: default to the held value first so no path leaves flags_d unassigned (no latch).
        flags_d = flags_q;
        if (!stall_i) begin
            if (flag_we_i) begin
                flags_d = flags_i;
            end
            if (carry_clr_i) begin
                flags_d.carry = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/regfile_wb.sv
// Writeback/operand stage: register file, R0 tap and ALU flag register.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_wb
    import regfile_wb_pkg::flags_t;
#(
    parameter  int DW    = regfile_wb_pkg::DW,
    parameter  int NREGS = regfile_wb_pkg::NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    input  logic [AW-1:0] waddr_first_i,
    input  logic [DW-1:0] rslt_i,
    input  logic          write_first_i,
    input  logic          write_r0_i,
    input  logic          flag_we_i,
    input  logic          carry_clr_i,
    input  logic          sc_i,
    input  logic          zero_i,
    input  logic          pari_i,
    input  logic          equal_i,
    output logic [DW-1:0] data_a_o,
    output logic [DW-1:0] data_b_o,
    output logic [DW-1:0] r0_o,
    output logic          carry_o,
    output logic          zero_o,
    output logic          pari_o,
    output logic          equal_o
);

    logic [DW-1:0] regs_d [NREGS];
    logic [DW-1:0] regs_q [NREGS];

    logic   wr_first_en;
    logic   wr_r0_en;
    flags_t flags_in;
    flags_t flags_out;

    assign wr_first_en = write_first_i && !stall_i;
    assign wr_r0_en    = write_r0_i && !stall_i;

    always_comb begin
        regs_d = regs_q;
        if (wr_first_en) begin
            regs_d[waddr_first_i] = rslt_i;
        end
        if (wr_r0_en) begin
            regs_d[0] = rslt_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the register array is reset explicitly; it is small and software expects zeros.
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_first_en;
    logic byp_r0_en;

    assign byp_first_en = wr_first_en && rst_n;
    assign byp_r0_en    = wr_r0_en && rst_n;

    // A port hits when it reads either destination being written this cycle.
    always_comb begin
        data_a_o = regs_q[raddr_a_i];
        data_b_o = regs_q[raddr_b_i];
        r0_o     = regs_q[0];
        if ((byp_first_en && raddr_a_i == waddr_first_i) || (byp_r0_en && raddr_a_i == '0)) begin
            data_a_o = rslt_i;
        end
        if ((byp_first_en && raddr_b_i == waddr_first_i) || (byp_r0_en && raddr_b_i == '0)) begin
            data_b_o = rslt_i;
        end
        if ((byp_first_en && waddr_first_i == '0) || byp_r0_en) begin
            r0_o = rslt_i;
        end
    end
`else
    assign data_a_o = regs_q[raddr_a_i];
    assign data_b_o = regs_q[raddr_b_i];
    assign r0_o     = regs_q[0];
`endif

    assign flags_in = '{carry: sc_i, zero: zero_i, pari: pari_i, equal: equal_i};

    wb_flags u_flags (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_i),
        .flag_we_i   (flag_we_i),
        .carry_clr_i (carry_clr_i),
        .flags_i     (flags_in),
        .flags_o     (flags_out)
    );

    assign carry_o = flags_out.carry;
    assign zero_o  = flags_out.zero;
    assign pari_o  = flags_out.pari;
    assign equal_o = flags_out.equal;

endmodule
